// File: rtl/alu_pkg.sv
// Package for the shared ALU arbiter slice.
// Contents:
//   - default datapath width and requester count
//   - opcode encodings
//   - FSM state encoding
//   - signed-overflow helper function
package alu_pkg;

    localparam int W    = 64;
    localparam int NREQ = 2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Overflow of an addition y = a + b', given the sign bits of a, b' and y.
    // For SUB the caller passes the inverted sign of b, since a - b = a + ~b + 1.
    function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                        input logic sign_y);
        return (sign_a == sign_b) && (sign_y != sign_a);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: (op, a, b) -> (y, ovf, err).
// Ports:
//   op   in  3   opcode (ADD/SUB/AND/OR/XOR; 5..7 illegal)
//   a    in  W   operand A (two's complement)
//   b    in  W   operand B (two's complement)
//   y    out W   result, wraps modulo 2^W; zero for illegal opcodes
//   ovf  out 1   signed overflow, only meaningful for ADD/SUB
//   err  out 1   illegal opcode
module alu_core
    import alu_pkg::*;
#(
    parameter int W = alu_pkg::W
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         ovf,
    output logic         err
);

    // Opcode decode and result/flag generation.
    always_comb begin
        y   = '0;
        ovf = 1'b0;
        err = 1'b0;
        case (op)
            OP_ADD: begin
                y   = a + b;
                ovf = signed_ovf(a[W-1], b[W-1], y[W-1]);
            end
            OP_SUB: begin
                y   = a - b;
                ovf = signed_ovf(a[W-1], ~b[W-1], y[W-1]);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            default: begin
                y   = '0;
                ovf = 1'b0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for one shared ALU.
// A request is accepted in IDLE, executed in EXEC and held as a tagged
// response in RESP until the consumer takes it.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_op/req_a/req_b   per-requester operands, requester i in slice i
//   rsp_valid/rsp_ready  response handshake
//   rsp_id               index of the requester owning the response
//   rsp_y/rsp_ovf/rsp_err  result, signed overflow, illegal opcode
//   busy                 high while in EXEC or RESP
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int W    = alu_pkg::W,
    parameter int NREQ = alu_pkg::NREQ
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*3-1:0] req_op,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [W-1:0]      rsp_y,
    output logic              rsp_ovf,
    output logic              rsp_err,
    output logic              busy
);

    state_e         state_r;
    state_e         state_nxt_s;
    logic           rr_ptr_r;
    logic           grant_s;
    logic           any_valid_s;
    logic           accept_s;
    logic [NREQ-1:0] req_ready_s;

    logic [2:0]     op_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           id_r;
    logic [W-1:0]   y_r;
    logic           ovf_r;
    logic           err_r;

    logic [W-1:0]   alu_y_s;
    logic           alu_ovf_s;
    logic           alu_err_s;

    // Grant selection: the pointer holder wins, otherwise the other requester.
    always_comb begin
        any_valid_s = |req_valid;
        if (req_valid[rr_ptr_r]) begin
            grant_s = rr_ptr_r;
        end else begin
            grant_s = ~rr_ptr_r;
        end
    end

    // Next-state logic and combinational accept.
    always_comb begin
        state_nxt_s = state_r;
        req_ready_s = '0;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    req_ready_s[grant_s] = 1'b1;
                    accept_s             = 1'b1;
                    state_nxt_s          = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Round-robin pointer: hand priority to the other requester once a response retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= 1'b0;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rr_ptr_r <= ~id_r;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Operand capture from the granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 3'd0;
            a_r  <= '0;
            b_r  <= '0;
            id_r <= 1'b0;
        end else if (accept_s) begin
            op_r <= grant_s ? req_op[5:3]     : req_op[2:0];
            a_r  <= grant_s ? req_a[2*W-1:W]  : req_a[W-1:0];
            b_r  <= grant_s ? req_b[2*W-1:W]  : req_b[W-1:0];
            id_r <= grant_s;
        end else begin
            op_r <= op_r;
            a_r  <= a_r;
            b_r  <= b_r;
            id_r <= id_r;
        end
    end

    alu_core #(.W(W)) u_alu_core (
        .op  (op_r),
        .a   (a_r),
        .b   (b_r),
        .y   (alu_y_s),
        .ovf (alu_ovf_s),
        .err (alu_err_s)
    );

    // Result registers, loaded in EXEC and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r   <= '0;
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            y_r   <= alu_y_s;
            ovf_r <= alu_ovf_s;
            err_r <= alu_err_s;
        end else begin
            y_r   <= y_r;
            ovf_r <= ovf_r;
            err_r <= err_r;
        end
    end

    // Accept is forced low while reset is asserted so every output reads zero.
    assign req_ready = req_ready_s & {NREQ{rst_n}};
    assign rsp_valid = (state_r == ST_RESP);
    assign busy      = (state_r != ST_IDLE);
    assign rsp_id    = id_r;
    assign rsp_y     = y_r;
    assign rsp_ovf   = ovf_r;
    assign rsp_err   = err_r;

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

    localparam int W = 64;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [5:0]      req_op;
    logic [2*W-1:0]  req_a;
    logic [2*W-1:0]  req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [W-1:0]    rsp_y;
    logic            rsp_ovf;
    logic            rsp_err;
    logic            busy;

    alu_req_arbiter #(.W(W), .NREQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_ovf   (rsp_ovf),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [63:0] y;
        logic        ovf;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        r;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] y;
        logic        ovf;
        logic        err;
    } vec_t;

    exp_t   q[$];
    exp_t   pend [2];
    vec_t   vecs [14];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    logic   tb_ptr  = 1'b0;
    logic   rv_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response checker: latency on rising rsp_valid, contents on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            rv_prev = 1'b0;
        end else begin
            if (rsp_valid && !rv_prev) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", {63'd0, rsp_valid}, 64'd0);
                end else begin
                    chk("latency", 64'(cyc - q[0].cyc), 64'd2);
                end
            end
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id",  {63'd0, rsp_id},  {63'd0, e.id});
                chk("rsp_y",   rsp_y,            e.y);
                chk("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                tb_ptr = ~e.id;
            end
            rv_prev = rsp_valid;
        end
    end

    task automatic post(input logic r, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] y,
                        input logic ovf, input logic err);
        if (r) begin
            req_op[5:3]     = op;
            req_a[2*W-1:W]  = a;
            req_b[2*W-1:W]  = b;
        end else begin
            req_op[2:0]     = op;
            req_a[W-1:0]    = a;
            req_b[W-1:0]    = b;
        end
        pend[r].id  = r;
        pend[r].y   = y;
        pend[r].ovf = ovf;
        pend[r].err = err;
        req_valid[r] = 1'b1;
    endtask

    // One clock: observe accepts at negedge, drop accepted valids after posedge.
    task automatic step();
        logic [1:0] acc;
        logic       eg;
        exp_t       e;
        @(negedge clk);
        acc = req_valid & req_ready;
        if (req_ready != 2'b00) begin
            eg = req_valid[tb_ptr] ? tb_ptr : ~tb_ptr;
            chk("grant", {62'd0, req_ready}, eg ? 64'd2 : 64'd1);
            e = pend[eg];
            e.cyc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic pump();
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            step();
            n++;
            done = (req_valid == 2'b00) && (q.size() == 0) && !rsp_valid;
        end
        chk("pump_done", {63'd0, done}, 64'd1);
    endtask

    initial begin
        logic [63:0] snap_y;
        logic [2:0]  snap_f;
        int          n;

        vecs[0]  = '{1'b0, 3'd4, 64'h405, 64'h403, 64'h6, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 3'd1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 3'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 64'h00F0_00F0_00F0_00F0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3'd3, 64'h1200, 64'h0034, 64'h1234, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'd1, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'd1, 64'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 3'd6, 64'h1234, 64'h5678, 64'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 64'h2, 64'h3, 64'h5, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 3'd7, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {59'd0, rsp_valid, busy, rsp_id, rsp_ovf, rsp_err}, 64'd0);
        chk("reset_y", rsp_y, 64'd0);
        chk("reset_ready", {62'd0, req_ready}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-requester vectors
        for (int i = 0; i < 14; i++) begin
            post(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].y, vecs[i].ovf, vecs[i].err);
            pump();
        end

        // Simultaneous requests, pointer at 0: req0 first, then req1, twice
        post(1'b0, 3'd2, 64'hFF, 64'h0F, 64'h0F, 1'b0, 1'b0);
        post(1'b1, 3'd3, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0);
        pump();
        post(1'b0, 3'd4, 64'h1, 64'h3, 64'h2, 1'b0, 1'b0);
        post(1'b1, 3'd0, 64'h10, 64'h20, 64'h30, 1'b0, 1'b0);
        pump();

        // Backpressure: hold RESP, new request must not be granted
        rsp_ready = 1'b0;
        post(1'b0, 3'd0, 64'h100, 64'h23, 64'h123, 1'b0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        chk("bp_reached_resp", {63'd0, rsp_valid}, 64'd1);
        snap_y = rsp_y;
        snap_f = {rsp_id, rsp_ovf, rsp_err};
        post(1'b1, 3'd1, 64'h10, 64'h1, 64'hF, 1'b0, 1'b0);
        repeat (5) begin
            step();
            chk("bp_y_stable", rsp_y, snap_y);
            chk("bp_flags_stable", {61'd0, rsp_id, rsp_ovf, rsp_err}, {61'd0, snap_f});
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_no_grant", {62'd0, req_ready}, 64'd0);
            chk("bp_busy", {63'd0, busy}, 64'd1);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", {63'd0, rsp_valid}, 64'd0);
        chk("bp_release_idle", {63'd0, busy}, 64'd0);
        chk("bp_next_grant", {62'd0, req_ready}, 64'd2);
        pump();

        // Leave the pointer at 1 with a nonzero held result
        post(1'b0, 3'd3, 64'h0AA0, 64'h0505, 64'h0FA5, 1'b0, 1'b0);
        pump();

        // Reset while in EXEC
        req_op[2:0]  = 3'd0;
        req_a[W-1:0] = 64'h1;
        req_b[W-1:0] = 64'h1;
        req_valid    = 2'b01;
        @(negedge clk);
        chk("rst_grant", {62'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        chk("rst_in_exec", {63'd0, busy}, 64'd1);
        rst_n  = 1'b0;
        tb_ptr = 1'b0;
        #1;
        chk("rst_async_flags", {59'd0, rsp_valid, busy, rsp_id, rsp_ovf, rsp_err}, 64'd0);
        chk("rst_async_y", rsp_y, 64'd0);
        chk("rst_async_ready", {62'd0, req_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            step();
            chk("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        // Pointer must be back at 0: req0 wins
        post(1'b0, 3'd4, 64'h0F, 64'hF0, 64'hFF, 1'b0, 1'b0);
        post(1'b1, 3'd2, 64'h3, 64'h1, 64'h1, 1'b0, 1'b0);
        pump();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
